// File: rtl/reg_port_arbiter_if.sv
// Shared register-file port bundle: two requesters plus the
// register-file control/data lines driven by the arbiter.
interface reg_port_arbiter_if #(
    parameter int PW = 4
);
    logic          req0, req1;
    logic          we0, we1;
    logic          acc0, acc1;
    logic          imm0, imm1;
    logic [PW:0]   addr0, addr1;
    logic [7:0]    wdata0, wdata1;
    logic          gnt0, gnt1;
    logic [7:0]    rd_data;
    logic          busy;
    logic [7:0]    rf_dat_in;
    logic [PW:0]   rf_addr;
    logic          rf_imm_val;
    logic          rf_acc_write;
    logic          rf_reg_write;
    logic [7:0]    rf_reg_out;

    modport slave (
        input  req0, req1, we0, we1, acc0, acc1, imm0, imm1,
        input  addr0, addr1, wdata0, wdata1, rf_reg_out,
        output gnt0, gnt1, rd_data, busy,
        output rf_dat_in, rf_addr, rf_imm_val,
        output rf_acc_write, rf_reg_write
    );

    modport master (
        output req0, req1, we0, we1, acc0, acc1, imm0, imm1,
        output addr0, addr1, wdata0, wdata1, rf_reg_out,
        input  gnt0, gnt1, rd_data, busy,
        input  rf_dat_in, rf_addr, rf_imm_val,
        input  rf_acc_write, rf_reg_write
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Two-port arbiter/sequencer for the accumulator register file.
// Optional post-reset zero scrub: define REG_PORT_ARB_SCRUB_EN.
module reg_port_arbiter #(
    parameter int PW         = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    reg_port_arbiter_if.slave bus
);
    typedef enum logic {SCRUB, RUN} state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);
`ifdef REG_PORT_ARB_SCRUB_EN
    localparam state_t RST_ST = SCRUB;
`else
    localparam state_t RST_ST = RUN;
`endif

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
`ifdef REG_PORT_ARB_SCRUB_EN
    logic [PW-1:0] ptr_q, ptr_d;
`endif
    logic          run, force1, g0, g1;
    logic [7:0]    dat;
    logic [PW:0]   addr;
    logic          imm, aw, rw;

    // State, scrub pointer and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RST_ST;
            starve_q <= '0;
`ifdef REG_PORT_ARB_SCRUB_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
`ifdef REG_PORT_ARB_SCRUB_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Next state: scrub walks every entry once, then stays in RUN
    always_comb begin
        state_d = state_q;
`ifdef REG_PORT_ARB_SCRUB_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            SCRUB: begin
`ifdef REG_PORT_ARB_SCRUB_EN
                ptr_d = ptr_q + PW'(1);
                if (ptr_q == '1) state_d = RUN;
`else
                state_d = RUN;
`endif
            end
            RUN: state_d = RUN;
        endcase
    end

    // Grant: req1 forced at the starvation limit, else req0 first
    always_comb begin
        run      = (state_q == RUN) && !reset;
        force1   = bus.req1 && (starve_q == LIM);
        g1       = run && bus.req1 && (force1 || !bus.req0);
        g0       = run && bus.req0 && !force1;
        starve_d = starve_q;
        if (run) begin
            if (!bus.req1 || g1)
                starve_d = '0;
            else if (starve_q != LIM)
                starve_d = starve_q + 4'd1;
        end
    end

    // Register-file port drive: scrub write, granted requester, or idle
    always_comb begin
        dat  = '0;
        addr = '0;
        imm  = 1'b0;
        aw   = 1'b0;
        rw   = 1'b0;
        if (!reset) begin
`ifdef REG_PORT_ARB_SCRUB_EN
            if (state_q == SCRUB) begin
                rw   = 1'b1;
                addr = {1'b0, ptr_q};
            end else
`endif
            if (g1) begin
                addr = bus.addr1;
                dat  = bus.wdata1;
                imm  = bus.imm1;
                aw   = bus.we1 & bus.acc1;
                rw   = bus.we1 & ~bus.acc1;
            end else if (g0) begin
                addr = bus.addr0;
                dat  = bus.wdata0;
                imm  = bus.imm0;
                aw   = bus.we0 & bus.acc0;
                rw   = bus.we0 & ~bus.acc0;
            end
        end
    end

`ifdef REG_PORT_ARB_SCRUB_EN
    assign bus.busy = reset || (state_q == SCRUB);
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.gnt0         = g0;
    assign bus.gnt1         = g1;
    assign bus.rd_data      = bus.rf_reg_out;
    assign bus.rf_dat_in    = dat;
    assign bus.rf_addr      = addr;
    assign bus.rf_imm_val   = imm;
    assign bus.rf_acc_write = aw;
    assign bus.rf_reg_write = rw;
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Testbench for reg_port_arbiter with a behavioural register file
// and a queue of expected port states per cycle.
module tb_reg_port_arbiter;
    localparam int PW = 4;
`ifdef REG_PORT_ARB_SCRUB_EN
    localparam logic       SCR  = 1'b1;
    localparam logic [7:0] BASE = 8'h00;
`else
    localparam logic       SCR  = 1'b0;
    localparam logic [7:0] BASE = 8'hEE;
`endif

    typedef struct packed {
        logic       g0, g1, bz, rw, aw, im;
        logic [4:0] a;
        logic [7:0] d;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic [7:0] rd;
        bit         crd;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_port_arbiter_if #(.PW(PW)) bus();

    reg_port_arbiter #(.PW(PW), .STARVE_LIM(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] mem [16];
    bit         seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'hEE;
            seeded <= 1'b1;
        end else begin
            if (bus.rf_reg_write) mem[bus.rf_addr[3:0]] <= bus.rf_dat_in;
            if (bus.rf_acc_write) mem[0] <= bus.rf_dat_in;
        end
    end

    assign bus.rf_reg_out = bus.rf_imm_val ? {3'b000, bus.rf_addr}
                                           : mem[bus.rf_addr[3:0]];

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic ctl_t obs();
        return {bus.gnt0, bus.gnt1, bus.busy, bus.rf_reg_write,
                bus.rf_acc_write, bus.rf_imm_val, bus.rf_addr,
                bus.rf_dat_in};
    endfunction

    function automatic ctl_t mk(input logic g0, g1, bz, rw, aw, im,
                                input logic [4:0] a,
                                input logic [7:0] d);
        return {g0, g1, bz, rw, aw, im, a, d};
    endfunction

    task automatic idle_in();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.acc0 = 0; bus.acc1 = 0; bus.imm0 = 0; bus.imm1 = 0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        ctl_t o;
        idle_in();
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 1;
        bus.addr0 = 5; bus.wdata0 = 8'h09;
        q.push_back('{c: mk(0,0,SCR,0,0,0,0,0), rd: 8'h00, crd: 1'b0});
        @(negedge clk);
        e = q.pop_front(); o = obs(); n_chk++;
        if (o !== e.c) begin
            n_err++;
            $display("FAIL reset_outputs got %h want %h", o, e.c);
        end
        step();
    endtask

    task automatic test_scrub();
        exp_t e;
        ctl_t o;
        idle_in();
        reset = 0;
        bus.req0 = 1; bus.addr0 = 3;
`ifdef REG_PORT_ARB_SCRUB_EN
        for (int i = 0; i < 16; i++) begin
            q.push_back('{c: mk(0,0,1,1,0,0,5'(i),0), rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL scrub cyc %0d got %h want %h", i, o, e.c);
            end
            step();
        end
`endif
        q.push_back('{c: mk(1,0,0,0,0,0,3,0), rd: BASE, crd: 1'b1});
        @(negedge clk);
        e = q.pop_front(); o = obs(); n_chk++;
        if (o !== e.c) begin
            n_err++;
            $display("FAIL first_grant got %h want %h", o, e.c);
        end
        if (e.crd) begin
            n_chk++;
            if (bus.rd_data !== e.rd) begin
                n_err++;
                $display("FAIL first_read got %h want %h",
                         bus.rd_data, e.rd);
            end
        end
        step();
    endtask

    task automatic test_basic();
        exp_t e;
        ctl_t o;
        for (int i = 0; i < 4; i++) begin
            idle_in();
            unique case (i)
                0: begin
                    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7;
                    bus.wdata0 = 8'h5A;
                    q.push_back('{c: mk(1,0,0,1,0,0,7,8'h5A),
                                  rd: 0, crd: 0});
                end
                1: begin
                    bus.req0 = 1; bus.addr0 = 7; bus.wdata0 = 8'h5A;
                    q.push_back('{c: mk(1,0,0,0,0,0,7,8'h5A),
                                  rd: 8'h5A, crd: 1});
                end
                2: begin
                    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 9;
                    bus.wdata1 = 8'h3C;
                    q.push_back('{c: mk(0,1,0,1,0,0,9,8'h3C),
                                  rd: 0, crd: 0});
                end
                default: begin
                    bus.req1 = 1; bus.addr1 = 9;
                    q.push_back('{c: mk(0,1,0,0,0,0,9,0),
                                  rd: 8'h3C, crd: 1});
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL basic %0d got %h want %h", i, o, e.c);
            end
            if (e.crd) begin
                n_chk++;
                if (bus.rd_data !== e.rd) begin
                    n_err++;
                    $display("FAIL basic_rd %0d got %h want %h",
                             i, bus.rd_data, e.rd);
                end
            end
            step();
        end
    endtask

    task automatic test_acc_imm();
        exp_t e;
        ctl_t o;
        for (int i = 0; i < 5; i++) begin
            idle_in();
            unique case (i)
                0: begin
                    bus.req1 = 1; bus.we1 = 1; bus.acc1 = 1;
                    bus.addr1 = 5; bus.wdata1 = 8'h22;
                    q.push_back('{c: mk(0,1,0,0,1,0,5,8'h22),
                                  rd: 0, crd: 0});
                end
                1: begin
                    bus.req0 = 1; bus.addr0 = 0;
                    q.push_back('{c: mk(1,0,0,0,0,0,0,0),
                                  rd: 8'h22, crd: 1});
                end
                2: begin
                    bus.req0 = 1; bus.addr0 = 5;
                    q.push_back('{c: mk(1,0,0,0,0,0,5,0),
                                  rd: BASE, crd: 1});
                end
                3: begin
                    bus.req0 = 1; bus.imm0 = 1; bus.addr0 = 5'h13;
                    q.push_back('{c: mk(1,0,0,0,0,1,5'h13,0),
                                  rd: 8'h13, crd: 1});
                end
                default: begin
                    bus.req0 = 1; bus.acc0 = 1; bus.addr0 = 2;
                    q.push_back('{c: mk(1,0,0,0,0,0,2,0),
                                  rd: BASE, crd: 1});
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL acc_imm %0d got %h want %h", i, o, e.c);
            end
            if (e.crd) begin
                n_chk++;
                if (bus.rd_data !== e.rd) begin
                    n_err++;
                    $display("FAIL acc_imm_rd %0d got %h want %h",
                             i, bus.rd_data, e.rd);
                end
            end
            step();
        end
    endtask

    task automatic test_starve();
        exp_t e;
        ctl_t o;
        logic s;
        idle_in();
        step();
        bus.req0 = 1; bus.addr0 = 1;
        bus.req1 = 1; bus.addr1 = 2;
        for (int i = 0; i < 15; i++) begin
            s = (i % 5 == 4);
            q.push_back('{c: mk(!s, s, 0,0,0,0, s ? 5'd2 : 5'd1, 0),
                          rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL starve cyc %0d got %h want %h", i, o, e.c);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        ctl_t o;
        logic s;
        for (int i = 0; i < 3; i++) begin
            q.push_back('{c: mk(1,0,0,0,0,0,1,0), rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL buildup cyc %0d got %h want %h", i, o, e.c);
            end
            step();
        end
        reset = 1;
        q.push_back('{c: mk(0,0,SCR,0,0,0,0,0), rd: 0, crd: 0});
        @(negedge clk);
        e = q.pop_front(); o = obs(); n_chk++;
        if (o !== e.c) begin
            n_err++;
            $display("FAIL mid_reset got %h want %h", o, e.c);
        end
        step();
        reset = 0;
`ifdef REG_PORT_ARB_SCRUB_EN
        for (int i = 0; i < 16; i++) begin
            q.push_back('{c: mk(0,0,1,1,0,0,5'(i),0), rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL rescrub cyc %0d got %h want %h", i, o, e.c);
            end
            step();
        end
`endif
        for (int i = 0; i < 5; i++) begin
            s = (i == 4);
            q.push_back('{c: mk(!s, s, 0,0,0,0, s ? 5'd2 : 5'd1, 0),
                          rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL post_reset cyc %0d got %h want %h",
                         i, o, e.c);
            end
            step();
        end
`ifdef REG_PORT_ARB_SCRUB_EN
        idle_in();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 27; i++) begin
            if (i == 9) begin
                reset = 1;
                q.push_back('{c: mk(0,0,1,0,0,0,0,0), rd: 0, crd: 0});
            end else if (i < 9) begin
                q.push_back('{c: mk(0,0,1,1,0,0,5'(i),0), rd: 0, crd: 0});
            end else if (i < 26) begin
                q.push_back('{c: mk(0,0,1,1,0,0,5'(i-10),0),
                              rd: 0, crd: 0});
            end else begin
                q.push_back('{c: mk(0,0,0,0,0,0,0,0), rd: 0, crd: 0});
            end
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL scrub_reset cyc %0d got %h want %h",
                         i, o, e.c);
            end
            step();
            reset = 0;
        end
`endif
    endtask

    task automatic test_idle();
        exp_t e;
        ctl_t o;
        logic s;
        idle_in();
        for (int i = 0; i < 10; i++) begin
            q.push_back('{c: mk(0,0,0,0,0,0,0,0), rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL idle cyc %0d got %h want %h", i, o, e.c);
            end
            step();
        end
        bus.req0 = 1; bus.addr0 = 4;
        bus.req1 = 1; bus.addr1 = 6;
        for (int i = 0; i < 5; i++) begin
            s = (i == 4);
            q.push_back('{c: mk(!s, s, 0,0,0,0, s ? 5'd6 : 5'd4, 0),
                          rd: 0, crd: 0});
            @(negedge clk);
            e = q.pop_front(); o = obs(); n_chk++;
            if (o !== e.c) begin
                n_err++;
                $display("FAIL after_idle cyc %0d got %h want %h",
                         i, o, e.c);
            end
            step();
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_scrub();
        test_basic();
        test_acc_imm();
        test_starve();
        test_reset_mid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
